// File: rtl/string_splitter_if.sv
// string_splitter_if: load-side and letter-side handshake bundle of string_splitter.
// The DUT uses the slave modport; the string producer/letter consumer uses master.
interface string_splitter_if #(
  parameter int NCHARS = 5
);
  logic [8*NCHARS-1:0] str;
  logic load;
  logic load_ready;
  logic [7:0] letter;
  logic letter_valid;
  logic letter_ready;
  logic busy;
  logic [2:0] index;
  logic done;
  modport master (
    output str, load, letter_ready,
    input load_ready, letter, letter_valid, busy, index, done
  );
  modport slave (
    input str, load, letter_ready,
    output load_ready, letter, letter_valid, busy, index, done
  );
endinterface

// File: rtl/string_splitter.sv
// string_splitter: emits a packed NCHARS-letter string one letter per valid/ready handshake.
// Define SPLITTER_SKIP_NUL_EN to silently consume NUL bytes instead of presenting them.
module string_splitter #(
  parameter int NCHARS = 5,
  parameter int GAP_CYCLES = 0
) (
  input logic CLK100MHZ,
  input logic CPU_RESETN,
  string_splitter_if.slave bus
);
  localparam int W = 8 * NCHARS;
  localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
`ifdef SPLITTER_SKIP_NUL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] sh, sh_n;
  logic [2:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic valid, valid_n;
  logic busy, busy_n;
  logic done, done_n;
  logic skip, adv, last;
  assign skip = SKIP && state == EMIT && sh[W-1 -: 8] == 8'h00;
  assign adv = skip || (valid && bus.letter_ready);
  assign last = idx == 3'(NCHARS - 1);
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      cnt <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      cnt <= cnt_n;
      valid <= valid_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.load) begin
        state_n = EMIT;
        sh_n = bus.str;
        idx_n = '0;
      end
      EMIT: if (adv) begin
        sh_n = {sh[W-9:0], 8'h00};
        idx_n = idx + 3'd1;
        cnt_n = '0;
        state_n = last ? DONE : (GAP_CYCLES > 0 && !skip) ? GAP : EMIT;
      end
      GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(GAP_CYCLES - 1)) state_n = EMIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered, so they are decoded from the upcoming state and data.
  always_comb begin
    valid_n = state_n == EMIT && !(SKIP && sh_n[W-1 -: 8] == 8'h00);
    busy_n = state_n != IDLE;
    done_n = state_n == DONE;
  end
  assign bus.load_ready = state == IDLE;
  assign bus.letter = sh[W-1 -: 8];
  assign bus.letter_valid = valid;
  assign bus.busy = busy;
  assign bus.index = idx;
  assign bus.done = done;
endmodule
